// File: rtl/chan_packet_pulse_wr_sched.sv
// Round-robin write scheduler for the chan_packet pulse BRAM.
// Grants one requester per cycle, registers the BRAM write one cycle later,
// and publishes the committed write pointer with half-buffer status flags.
module chan_packet_pulse_wr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int AW   = 12
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    input  logic                 run,
    input  logic                 clear,
    input  logic                 half_ack,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 bram_we,
    output logic [AW-1:0]        bram_addr,
    output logic [DW-1:0]        bram_din,
    output logic [31:0]          pulses_addr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);
    localparam logic [IW:0]   NREQ_W = (IW + 1)'(NREQ);

    logic [NREQ-1:0][DW-1:0] req_word;
    logic [IW-1:0]           rr_last;
    logic [IW-1:0]           grant_idx;
    logic                    grant_any;
    logic                    xfer;
    logic [AW-1:0]           wr_ptr;
    logic                    pending, overflow, ack_q;
    logic                    ack_rise, half_done;
    logic                    pend_nxt, ovf_nxt;
    logic [AW-1:0]           commit_ptr;
    logic [31:0]             status_nxt;

    assign req_word = req_data;

    // Rotating priority search starting just after the last winner
    always_comb begin
        logic [IW:0] cand;
        grant_any = 1'b0;
        grant_idx = rr_last;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_last} + (IW + 1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!grant_any && req_valid[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    // Ready is gated by reset too, so every output reads 0 while reset is held
    assign xfer = grant_any & run & ~clear & user_rst_n;

    // One-hot ready toward the winning requester
    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant_idx] = 1'b1;
    end

    // A half completes when the registered write lands on the last word of either half
    assign half_done = bram_we & (&bram_addr[AW-2:0]);
    assign ack_rise  = half_ack & ~ack_q;

    // Ack is applied first so a simultaneous completion re-arms pending without overflow
    always_comb begin
        pend_nxt = pending;
        ovf_nxt  = overflow;
        if (ack_rise) pend_nxt = 1'b0;
        if (half_done) begin
            if (pend_nxt) ovf_nxt = 1'b1;
            pend_nxt = 1'b1;
        end
    end

    // Status follows committed writes only, not the speculative wr_ptr
    assign commit_ptr = bram_we ? (bram_addr + AW'(1)) : pulses_addr[AW-1:0];
    assign status_nxt = {ovf_nxt, pend_nxt, commit_ptr[AW-1], (29 - AW)'(0), commit_ptr};

    // Write pipeline, arbitration history and status registers
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            wr_ptr      <= '0;
            rr_last     <= LAST;
            pending     <= 1'b0;
            overflow    <= 1'b0;
            pulses_addr <= '0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= half_ack;
            if (clear) begin
                bram_we     <= 1'b0;
                bram_addr   <= '0;
                bram_din    <= '0;
                wr_ptr      <= '0;
                rr_last     <= LAST;
                pending     <= 1'b0;
                overflow    <= 1'b0;
                pulses_addr <= '0;
            end else begin
                bram_we <= xfer;
                if (xfer) begin
                    bram_addr <= wr_ptr;
                    bram_din  <= req_word[grant_idx];
                    wr_ptr    <= wr_ptr + AW'(1);
                    rr_last   <= grant_idx;
                end
                pending     <= pend_nxt;
                overflow    <= ovf_nxt;
                pulses_addr <= status_nxt;
            end
        end
    end

endmodule
